// File: rtl/switch_cond_pkg.sv
// Shared types and defaults for the switch conditioner: FSM state encoding
// and default synchroniser/debounce depths.
package switch_cond_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b10,
    FALL_CHK = 2'b11
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

  function automatic logic is_checking(input state_e s);
    return (s == RISE_CHK) || (s == FALL_CHK);
  endfunction

endpackage

// File: rtl/switch_conditioner_sync.sv
// bit_synchronizer: STAGES-deep flop chain bringing an asynchronous level
// into the clk domain; q is the last stage.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // shift the raw level through the chain, clearing it on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/switch_conditioner.sv
// Switch debouncer: synchroniser plus four-state qualification FSM with
// registered level, pending flag and edge pulses (pulses only with SWITCH_COND_EDGE_EN).
module switch_conditioner
  import switch_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic switch_raw,
  output logic switch_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic pending
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_sync_q;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_switch_out;
  logic             w_switch_out_nxt;
  logic             r_pending;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (switch_raw),
    .q    (w_sync_q)
  );

  // next-state, counter and level decode; cnt == CNT_LAST means this sample is the last one needed
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_switch_out_nxt = r_switch_out;
    case (r_state)
      LOW: begin
        if (w_sync_q) begin
          w_state_nxt = RISE_CHK;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      RISE_CHK: begin
        if (!w_sync_q) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt      = HIGH;
          w_switch_out_nxt = 1'b1;
          w_cnt_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!w_sync_q) begin
          w_state_nxt = FALL_CHK;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      FALL_CHK: begin
        if (w_sync_q) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt      = LOW;
          w_switch_out_nxt = 1'b0;
          w_cnt_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt      = LOW;
        w_cnt_nxt        = '0;
        w_switch_out_nxt = 1'b0;
      end
    endcase
  end

  // state, counter and registered outputs; reset wins over a simultaneous acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LOW;
      r_cnt        <= '0;
      r_switch_out <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_switch_out <= w_switch_out_nxt;
      r_pending    <= is_checking(w_state_nxt);
    end
  end

  assign switch_out = r_switch_out;
  assign pending    = r_pending;

`ifdef SWITCH_COND_EDGE_EN
  logic r_rise_pulse;
  logic r_fall_pulse;

  // pulse on the accepting transition out of a check state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rise_pulse <= 1'b0;
      r_fall_pulse <= 1'b0;
    end else begin
      r_rise_pulse <= (r_state == RISE_CHK) && (w_state_nxt == HIGH);
      r_fall_pulse <= (r_state == FALL_CHK) && (w_state_nxt == LOW);
    end
  end

  assign rise_pulse = r_rise_pulse;
  assign fall_pulse = r_fall_pulse;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed scoreboard bench for switch_conditioner; expected output vectors
// {switch_out, rise_pulse, fall_pulse, pending} are queued per cycle.
module tb_switch_conditioner;

`ifdef SWITCH_COND_EDGE_EN
  localparam logic EDGE = 1'b1;
`else
  localparam logic EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic switch_raw;
  logic switch_out;
  logic rise_pulse;
  logic fall_pulse;
  logic pending;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  switch_conditioner dut (
    .clk       (clk),
    .reset     (reset),
    .switch_raw(switch_raw),
    .switch_out(switch_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ev(input logic o, input logic r, input logic f, input logic p);
    return {o, r, f, p};
  endfunction

  task automatic cyc(input logic rst, input logic raw, input logic [3:0] e, input string tag);
    exp_t       item;
    logic [3:0] obs;
    item.tag   = tag;
    item.exp   = e;
    reset      = rst;
    switch_raw = raw;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    obs  = {switch_out, rise_pulse, fall_pulse, pending};
    checks++;
    assert (obs === item.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (out,rise,fall,pend)", item.tag, obs, item.exp);
    end
  endtask

  // settled at !lvl, drive lvl: pending on edges k+2..k+4, level flips at k+5
  task automatic accept(input logic lvl, input string tag);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, lvl,
          ev((i == 5) ? lvl : !lvl,
             (i == 5) && lvl && EDGE,
             (i == 5) && !lvl && EDGE,
             (i >= 2) && (i <= 4)),
          tag);
    end
  endtask

  task automatic hold(input logic lvl, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, lvl, ev(lvl, 1'b0, 1'b0, 1'b0), tag);
    end
  endtask

  // three-cycle excursion to lvl from settled !lvl: qualified then aborted
  task automatic glitch(input logic lvl, input string tag);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, (i < 3) ? lvl : !lvl,
          ev(!lvl, 1'b0, 1'b0, (i >= 2) && (i <= 4)), tag);
    end
  endtask

  initial begin
    reset      = 1'b1;
    switch_raw = 1'b0;

    cyc(1'b1, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0), "reset_low");
    cyc(1'b1, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0), "reset_low");
    cyc(1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0), "reset_raw_high");
    accept(1'b1, "post_reset_rise");
    hold(1'b1, 4, "post_reset_hold");

    accept(1'b0, "fall");
    hold(1'b0, 4, "fall_hold");

    accept(1'b1, "rise10");
    hold(1'b1, 4, "rise10_hold");
    accept(1'b0, "fall2");
    hold(1'b0, 3, "fall2_hold");

    glitch(1'b1, "glitch_high");
    hold(1'b0, 2, "glitch_high_after");

    for (int g = 0; g < 3; g++) begin
      cyc(1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0), "bounce");
      cyc(1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0), "bounce");
      cyc(1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b1), "bounce");
      cyc(1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b1), "bounce");
    end
    accept(1'b1, "bounce_settle");
    hold(1'b1, 3, "bounce_hold");

    glitch(1'b0, "glitch_low");
    hold(1'b1, 2, "glitch_low_after");
    accept(1'b0, "fall3");
    hold(1'b0, 3, "fall3_hold");

    cyc(1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0), "pre_reset_qual");
    cyc(1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0), "pre_reset_qual");
    cyc(1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b1), "pre_reset_qual");
    cyc(1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b1), "pre_reset_qual");
    cyc(1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b1), "pre_reset_qual");
    cyc(1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0), "reset_vs_accept");
    accept(1'b1, "rise_after_reset");
    hold(1'b1, 2, "rise_after_reset_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
